// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared types and defaults for the IF-stage fetch controller
package pc_fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2} state_t;
  typedef enum logic [1:0] {NXT_HOLD, NXT_STEP, NXT_TGT, NXT_SAVED} nxt_sel_t;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF = 32'd4;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux choosing hold, sequential step, aligned branch target or saved target
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic [31:0] saved,
  input  nxt_sel_t    sel,
  output logic [31:0] pc_nxt
);
  // select the address loaded into the PC at the next edge
  always_comb
    pc_nxt = sel == NXT_STEP  ? pc + PC_STEP :
             sel == NXT_TGT   ? align_word(target) :
             sel == NXT_SAVED ? saved : pc;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, fetch request and IF/ID, ID/EX flush/hold control
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        dmem_busywait,
  input  logic        imem_busywait,
  output logic        imem_read,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_flush
);
  state_t      state, nxt_state;
  nxt_sel_t    sel;
  logic        save_en;
  logic [31:0] saved, pc_nxt;
  logic        frz, redir;
  assign frz = dmem_busywait;
  assign redir = pc_sel & ~frz;
  assign pc_plus4_out = pc_out + PC_STEP;
  pc_next_sel #(.PC_STEP(PC_STEP)) u_next (
    .pc     (pc_out),
    .target (branch_target),
    .saved  (saved),
    .sel    (sel),
    .pc_nxt (pc_nxt)
  );
  // state, PC and saved redirect target; the saved target is kept word aligned
  always_ff @(posedge clk)
    if (reset) begin
      state  <= BOOT;
      pc_out <= RESET_VECTOR;
      saved  <= '0;
    end else begin
      state  <= nxt_state;
      pc_out <= pc_nxt;
      if (save_en) saved <= align_word(branch_target);
    end
  // next state and PC source; a data-memory freeze holds everything
  always_comb begin
    nxt_state = state;
    sel = NXT_HOLD;
    save_en = 1'b0;
    if (!frz)
      case (state)
        BOOT: nxt_state = RUN;
        RUN:
          if (redir) begin
            save_en = imem_busywait;
            nxt_state = imem_busywait ? REDIR : RUN;
            sel = imem_busywait ? NXT_HOLD : NXT_TGT;
          end else if (!stall && !imem_busywait) sel = NXT_STEP;
        REDIR: begin
          save_en = redir;
          nxt_state = imem_busywait ? REDIR : RUN;
          sel = imem_busywait ? NXT_HOLD : redir ? NXT_TGT : NXT_SAVED;
        end
        default: nxt_state = BOOT;
      endcase
  end
  // fetch request, valid and pipeline-register controls decoded from state and inputs
  always_comb begin
    imem_read = 1'b0;
    instr_valid = 1'b0;
    if_id_hold = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b0;
    if (reset) id_ex_flush = 1'b1;
    else
      case (state)
        RUN: begin
          imem_read = 1'b1;
          id_ex_flush = redir;
          if_id_flush = redir | (~frz & ~stall & imem_busywait);
          if_id_hold = ~redir & (frz | stall);
          instr_valid = ~redir & ~frz & ~stall & ~imem_busywait;
        end
        REDIR: begin
          imem_read = 1'b1;
          id_ex_flush = redir;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed stimulus with a behavioural fetch model checked every cycle
module tb_pc_fetch_ctrl;
  logic        clk = 1'b1;
  logic        reset = 1'b1, pc_sel = 1'b0, stall = 1'b0, dmem_busywait = 1'b0, imem_busywait = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_read, instr_valid, if_id_hold, if_id_flush, id_ex_flush;
  logic [31:0] pc_out, pc_plus4_out;
  int tests = 0, fails = 0;
  logic        m_init = 1'b0, m_boot = 1'b0, m_pend = 1'b0;
  logic [31:0] m_pc = '0, m_tgt = '0;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .branch_target(branch_target),
    .stall(stall), .dmem_busywait(dmem_busywait), .imem_busywait(imem_busywait),
    .imem_read(imem_read), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .instr_valid(instr_valid), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // model: compare outputs mid-cycle, then advance by the rules of one clock edge
  always @(negedge clk) begin
    logic taken;
    logic [3:0] e;
    taken = pc_sel & ~dmem_busywait;
    if (m_init) begin
      if (reset) e = 4'b0011;
      else if (m_boot) e = 4'b0010;
      else if (m_pend) e = {1'b0, 1'b0, 1'b1, taken};
      else if (taken) e = 4'b0011;
      else if (dmem_busywait || stall) e = 4'b0100;
      else if (imem_busywait) e = 4'b0010;
      else e = 4'b1000;
      chk("imem_read", {31'b0, imem_read}, {31'b0, !reset && !m_boot});
      chk("valid_hold_ifflush_exflush", {28'b0, instr_valid, if_id_hold, if_id_flush, id_ex_flush}, {28'b0, e});
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4_out", pc_plus4_out, m_pc + 32'd4);
    end
    if (reset) begin
      m_init = 1'b1; m_boot = 1'b1; m_pend = 1'b0; m_pc = 32'h0; m_tgt = 32'h0;
    end else if (dmem_busywait) begin
    end else if (m_boot) m_boot = 1'b0;
    else if (m_pend) begin
      if (pc_sel) m_tgt = branch_target & ~32'd3;
      if (!imem_busywait) begin m_pc = m_tgt; m_pend = 1'b0; end
    end else if (pc_sel) begin
      if (imem_busywait) begin m_pend = 1'b1; m_tgt = branch_target & ~32'd3; end
      else m_pc = branch_target & ~32'd3;
    end else if (!stall && !imem_busywait) m_pc = m_pc + 32'd4;
  end

  task automatic cyc(input logic r, input logic s, input logic [31:0] t, input logic st, input logic d, input logic i);
    reset = r; pc_sel = s; branch_target = t; stall = st; dmem_busywait = d; imem_busywait = i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pin_reset_pc", pc_out, 32'h0);
    idle(1);
    chk("pin_after_boot_pc", pc_out, 32'h0);
    idle(2);
    chk("pin_seq_pc", pc_out, 32'h8);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1);
    chk("pin_ibusy_hold", pc_out, 32'h8);
    idle(1);
    chk("pin_after_ibusy", pc_out, 32'hC);
    idle(1);
    cyc(0, 1, 32'h103, 0, 0, 0);
    chk("pin_redirect_align", pc_out, 32'h100);
    cyc(0, 1, 32'h200, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("pin_redir_hold", pc_out, 32'h100);
    idle(1);
    chk("pin_redir_done", pc_out, 32'h200);
    cyc(0, 1, 32'h280, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 32'h302, 0, 0, 1);
    idle(1);
    chk("pin_youngest_wins", pc_out, 32'h300);
    cyc(0, 1, 32'h40, 1, 0, 0);
    chk("pin_stall_redirect", pc_out, 32'h40);
    cyc(0, 0, 0, 1, 0, 0);
    chk("pin_stall_hold", pc_out, 32'h40);
    for (int k = 0; k < 4; k++) cyc(0, 1, 32'h500, 0, 1, 0);
    chk("pin_freeze", pc_out, 32'h40);
    cyc(0, 1, 32'h500, 0, 0, 0);
    chk("pin_after_freeze", pc_out, 32'h500);
    cyc(0, 1, 32'h600, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("pin_reset_in_redir", pc_out, 32'h0);
    idle(2);
    chk("pin_restart", pc_out, 32'h4);
    cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    chk("pin_top_pc", pc_out, 32'hFFFF_FFFC);
    chk("pin_plus4_wrap", pc_plus4_out, 32'h0);
    idle(1);
    chk("pin_pc_wrap", pc_out, 32'h0);
    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
